// File: rtl/chirp_pinc_gen_if.sv
// AXI-Stream link carrying phase increments from chirp_pinc_gen to the DDS.
// Optional tlast is present only when CHIRP_TLAST_EN is defined.
interface chirp_pinc_gen_if #(
    parameter int PINC_W = 24
) ();
    logic [PINC_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
`ifdef CHIRP_TLAST_EN
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
`else
    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
`endif
endinterface

// File: rtl/chirp_pinc_gen.sv
// Stepped chirp phase-increment sequencer (up/down/triangle) driving a DDS PINC stream.
// Define CHIRP_TLAST_EN to drive m_axis.tlast on the final beat of every sweep.
//
// state | meaning
// IDLE  | stream quiet, cfg_load/start honoured
// RUN   | emitting sweep values on m_axis
// DONE  | one-cycle done pulse after the final sweep
module chirp_pinc_gen #(
    parameter int PINC_W  = 24,
    parameter int DWELL_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load_i,
    input  logic [PINC_W-1:0]  cfg_pinc_start_i,
    input  logic [PINC_W-1:0]  cfg_pinc_step_i,
    input  logic [CNT_W-1:0]   cfg_num_steps_i,
    input  logic [DWELL_W-1:0] cfg_dwell_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [CNT_W-1:0]   cfg_repeat_i,
    input  logic               start_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    chirp_pinc_gen_if.master   m_axis
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;

    state_t             state_q, state_d;
    logic [PINC_W-1:0]  start_q, start_d;
    logic [PINC_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   repeat_q, repeat_d;

    logic [PINC_W-1:0]  pinc_q, pinc_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [CNT_W-1:0]   step_idx_q, step_idx_d;
    logic               phase_dn_q, phase_dn_d;
    logic [CNT_W-1:0]   sweeps_q, sweeps_d;

    logic beat;
    logic seg_end;
    logic turn;
    logic sweep_last;
    logic go_down;

    assign beat       = (state_q == RUN) && m_axis.tready;
    assign seg_end    = (step_idx_q == num_q);
    // Triangle turns at the peak only once; the peak value is not repeated.
    assign turn       = seg_end && (mode_q == MODE_TRI) && !phase_dn_q && (num_q != '0);
    assign sweep_last = seg_end && !turn;
    assign go_down    = (mode_q == MODE_DOWN) || ((mode_q == MODE_TRI) && phase_dn_q);

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        step_d      = step_q;
        num_d       = num_q;
        dwell_d     = dwell_q;
        mode_d      = mode_q;
        repeat_d    = repeat_q;
        pinc_d      = pinc_q;
        dwell_cnt_d = dwell_cnt_q;
        step_idx_d  = step_idx_q;
        phase_dn_d  = phase_dn_q;
        sweeps_d    = sweeps_q;

        case (state_q)
            IDLE: begin
                if (!abort_i) begin
                    if (cfg_load_i) begin
                        start_d  = cfg_pinc_start_i;
                        step_d   = cfg_pinc_step_i;
                        num_d    = cfg_num_steps_i;
                        dwell_d  = cfg_dwell_i;
                        mode_d   = cfg_mode_i;
                        repeat_d = cfg_repeat_i;
                    end
                    if (start_i) begin
                        state_d     = RUN;
                        pinc_d      = start_d;
                        dwell_cnt_d = (dwell_d == '0) ? '0 : dwell_d - DWELL_W'(1);
                        step_idx_d  = '0;
                        phase_dn_d  = 1'b0;
                        sweeps_d    = repeat_d;
                    end
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (beat) begin
                    if (dwell_cnt_q != '0) begin
                        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                    end else begin
                        dwell_cnt_d = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
                        if (!seg_end) begin
                            pinc_d     = go_down ? pinc_q - step_q : pinc_q + step_q;
                            step_idx_d = step_idx_q + CNT_W'(1);
                        end else if (turn) begin
                            pinc_d     = pinc_q - step_q;
                            step_idx_d = CNT_W'(1);
                            phase_dn_d = 1'b1;
                        end else if ((repeat_q == '0) || (sweeps_q > CNT_W'(1))) begin
                            pinc_d     = start_q;
                            step_idx_d = '0;
                            phase_dn_d = 1'b0;
                            if (repeat_q != '0) begin
                                sweeps_d = sweeps_q - CNT_W'(1);
                            end
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= '0;
            step_q      <= '0;
            num_q       <= '0;
            dwell_q     <= '0;
            mode_q      <= '0;
            repeat_q    <= '0;
            pinc_q      <= '0;
            dwell_cnt_q <= '0;
            step_idx_q  <= '0;
            phase_dn_q  <= 1'b0;
            sweeps_q    <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            step_q      <= step_d;
            num_q       <= num_d;
            dwell_q     <= dwell_d;
            mode_q      <= mode_d;
            repeat_q    <= repeat_d;
            pinc_q      <= pinc_d;
            dwell_cnt_q <= dwell_cnt_d;
            step_idx_q  <= step_idx_d;
            phase_dn_q  <= phase_dn_d;
            sweeps_q    <= sweeps_d;
        end
    end

    assign m_axis.tvalid = (state_q == RUN);
    assign m_axis.tdata  = (state_q == RUN) ? pinc_q : '0;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
`ifdef CHIRP_TLAST_EN
    assign m_axis.tlast  = (state_q == RUN) && sweep_last && (dwell_cnt_q == '0);
`endif

endmodule
